// File: rtl/alu_share_arbiter_pkg.sv
// Shared constants for the ALU-sharing arbiter: op-select codes and state encoding.
package alu_share_arbiter_pkg;

    localparam int SEL_W = 4;

    // ALU op-select codes (decoded by the external ALU, passed through here)
    localparam logic [SEL_W-1:0] OP_ADD = 4'd0;
    localparam logic [SEL_W-1:0] OP_SUB = 4'd1;
    localparam logic [SEL_W-1:0] OP_SLT = 4'd2;
    localparam logic [SEL_W-1:0] OP_SGT = 4'd3;
    localparam logic [SEL_W-1:0] OP_AND = 4'd4;
    localparam logic [SEL_W-1:0] OP_OR  = 4'd5;
    localparam logic [SEL_W-1:0] OP_XOR = 4'd6;
    localparam logic [SEL_W-1:0] OP_NOT = 4'd7;
    localparam logic [SEL_W-1:0] OP_NOR = 4'd8;
    localparam logic [SEL_W-1:0] OP_LUI = 4'd9;
    localparam logic [SEL_W-1:0] OP_SLL = 4'd10;
    localparam logic [SEL_W-1:0] OP_SRL = 4'd11;
    localparam logic [SEL_W-1:0] OP_SRA = 4'd12;
    localparam logic [SEL_W-1:0] OP_INC = 4'd13;
    localparam logic [SEL_W-1:0] OP_DEC = 4'd14;
    localparam logic [SEL_W-1:0] OP_HAM = 4'd15;

    // Arbiter state: IDLE = no result held, RESP = result held for owner
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RESP = 1'b1;

endpackage

// File: rtl/alu_share_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or after rr_ptr, wrapping modulo N_REQ.
module rr_pick_n #(
    parameter int N_REQ = 2,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx
);

    // Walk offsets from farthest to nearest so the nearest requester from rr_ptr wins.
    always_comb begin : pick
        int c;
        logic [IDX_W-1:0] ci;
        grant = '0;
        idx   = '0;
        c     = 0;
        ci    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            c = int'(rr_ptr) + k;
            if (c >= N_REQ) c = c - N_REQ;
            ci = IDX_W'(c);
            if (req[ci]) begin
                grant     = '0;
                grant[ci] = 1'b1;
                idx       = ci;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU among N_REQ requesters with round-robin grant,
// one op in flight, and a registered result held until its owner accepts it.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEL_W = alu_share_arbiter_pkg::SEL_W,
    parameter int N_REQ = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    input  logic [N_REQ*SEL_W-1:0] req_sel,
    output logic [N_REQ-1:0]       rsp_valid,
    input  logic [N_REQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]       rsp_res,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    output logic [SEL_W-1:0]       alu_sel,
    input  logic [WIDTH-1:0]       alu_res,
    output logic [31:0]            ops_done
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [0:0]       state;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] rr_ptr;
    logic [WIDTH-1:0] rsp_res_q;
    logic [31:0]      ops_done_q;

    logic             rsp_hs;
    logic             can_accept;
    logic [N_REQ-1:0] req_eligible;
    logic [N_REQ-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_any;

    // Owner handshake completes the held result; it also frees the ALU slot this same cycle.
    // rst_n gates eligibility so nothing is granted while reset is held.
    always_comb begin
        rsp_hs       = (state == ST_RESP) && rsp_ready[owner];
        can_accept   = (state == ST_IDLE) || rsp_hs;
        req_eligible = req_valid & {N_REQ{can_accept & rst_n}};
    end

    rr_pick_n #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req_eligible),
        .rr_ptr (rr_ptr),
        .grant  (grant),
        .idx    (grant_idx)
    );

    // Grant doubles as ready; operands of the granted requester drive the ALU, else zeros.
    always_comb begin
        grant_any = |grant;
        req_ready = grant;
        alu_a     = '0;
        alu_b     = '0;
        alu_sel   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                alu_a   = req_a[i*WIDTH +: WIDTH];
                alu_b   = req_b[i*WIDTH +: WIDTH];
                alu_sel = req_sel[i*SEL_W +: SEL_W];
            end
        end
    end

    // Response channel: only the owner sees valid, and only while a result is held.
    always_comb begin
        rsp_valid = '0;
        if (state == ST_RESP) rsp_valid[owner] = 1'b1;
        rsp_res  = rsp_res_q;
        ops_done = ops_done_q;
    end

    // State, owner, result capture and round-robin pointer; a new grant wins over going idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            rsp_res_q <= '0;
        end else if (grant_any) begin
            state     <= ST_RESP;
            owner     <= grant_idx;
            rsp_res_q <= alu_res;
            rr_ptr    <= (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end else if (rsp_hs) begin
            state <= ST_IDLE;
        end
    end

    // Completed-response counter, free-running wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ops_done_q <= '0;
        else if (rsp_hs) ops_done_q <= ops_done_q + 32'd1;
    end

endmodule
